// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO reader block.
// Contents: payload/address width defaults, broadcast address, packet struct,
// controller state enum.
package fifo_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 2;

    // Destination address every reader accepts regardless of its own address.
    localparam logic [ADDR_W_DEF-1:0] BCAST_ADDR = '1;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] src;
        logic [ADDR_W_DEF-1:0] dst;
        logic [DATA_W_DEF-1:0] data;
    } pkt_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_reader_if.sv
// Bundle of the FIFO read port and the downstream packet stream.
// master: the reader (drives readp and the m_* stream, samples FIFO head and m_ready).
// slave : the surrounding FIFO and downstream consumer.
interface fifo_reader_if #(
    parameter int unsigned DATA_W = fifo_pkg::DATA_W_DEF,
    parameter int unsigned ADDR_W = fifo_pkg::ADDR_W_DEF
);
    logic              emptyp;
    logic [ADDR_W-1:0] src_out;
    logic [ADDR_W-1:0] dst_out;
    logic [DATA_W-1:0] data_out;
    logic              readp;
    logic              m_valid;
    logic              m_ready;
    logic [ADDR_W-1:0] m_src;
    logic [ADDR_W-1:0] m_dst;
    logic [DATA_W-1:0] m_data;

    modport master (
        input  emptyp, src_out, dst_out, data_out, m_ready,
        output readp, m_valid, m_src, m_dst, m_data
    );

    modport slave (
        output emptyp, src_out, dst_out, data_out, m_ready,
        input  readp, m_valid, m_src, m_dst, m_data
    );
endinterface

// File: rtl/skid_buf2.sv
// Two-entry in-order packet buffer with a valid/ready output side.
// Ports: clk, rst (async active-low), in_valid/in_data (push, caller guarantees
// room), out_valid/out_data/out_ready (head and pop), occ (entries held, 0..2).
module skid_buf2 #(
    parameter int unsigned W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic [1:0]   occ
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         pop_c;
    logic [1:0]   occ_nxt_c;

    assign pop_c     = out_valid & out_ready;
    assign occ_nxt_c = occ + 2'(in_valid) - 2'(pop_c);
    assign out_data  = mem[rd_ptr];

    // Storage, 1-bit wrapping pointers and occupancy; push and pop may share a cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0]    <= '0;
            mem[1]    <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occ       <= 2'd0;
            out_valid <= 1'b0;
        end else begin
            if (in_valid) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_c) begin
                rd_ptr <= ~rd_ptr;
            end
            occ       <= occ_nxt_c;
            out_valid <= (occ_nxt_c != 2'd0);
        end
    end
endmodule

// File: rtl/fifo_reader.sv
// Pulls packets from a 1-cycle-latency FIFO, filters them on destination address
// and presents accepted packets on a valid/ready stream, keeping statistics.
// Ports: clk, rst (async active-low), bus (fifo_reader_if.master: FIFO read port
// and downstream stream), rx_count (delivered), drop_count (filtered out).
module fifo_reader #(
    parameter int unsigned DATA_W  = fifo_pkg::DATA_W_DEF,
    parameter int unsigned ADDR_W  = fifo_pkg::ADDR_W_DEF,
    parameter int unsigned MY_ADDR = 0,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    fifo_reader_if.master    bus,
    output logic [CNT_W-1:0] rx_count,
    output logic [CNT_W-1:0] drop_count
);
    import fifo_pkg::*;

    localparam int unsigned       PKT_W = 2 * ADDR_W + DATA_W;
    localparam logic [ADDR_W-1:0] BCAST = '1;

    state_t           state;
    logic             started;
    logic             inflight;
    logic [1:0]       occ;
    logic [1:0]       occ_eff_c;
    logic [1:0]       occ_nxt_c;
    logic             match_c;
    logic             accept_c;
    logic             drop_c;
    logic             xfer_c;
    logic [PKT_W-1:0] head;

    // A FIFO return is only meaningful on the cycle after a pop was issued.
    assign match_c  = (bus.dst_out == ADDR_W'(MY_ADDR)) || (bus.dst_out == BCAST);
    assign accept_c = inflight & match_c;
    assign drop_c   = inflight & ~match_c;
    assign xfer_c   = bus.m_valid & bus.m_ready;

    // Slot freed by this cycle's transfer counts as free, so a steady stream has no bubble.
    assign occ_eff_c = occ - 2'(xfer_c);
    assign occ_nxt_c = occ_eff_c + 2'(accept_c);

    // Combinational so the pop request tracks the live empty flag.
    assign bus.readp = started && !bus.emptyp && (state != ST_FULL)
                       && ((occ_eff_c + 2'(inflight)) < 2'd2);

    skid_buf2 #(.W(PKT_W)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept_c),
        .in_data   ({bus.src_out, bus.dst_out, bus.data_out}),
        .out_valid (bus.m_valid),
        .out_data  (head),
        .out_ready (bus.m_ready),
        .occ       (occ)
    );

    assign {bus.m_src, bus.m_dst, bus.m_data} = head;

    // Pop tracking, saturating statistics and controller state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            started    <= 1'b0;
            inflight   <= 1'b0;
            rx_count   <= '0;
            drop_count <= '0;
            state      <= ST_IDLE;
        end else begin
            started  <= 1'b1;
            inflight <= bus.readp;
            if (xfer_c && (rx_count != '1)) begin
                rx_count <= rx_count + CNT_W'(1);
            end
            if (drop_c && (drop_count != '1)) begin
                drop_count <= drop_count + CNT_W'(1);
            end
            if (occ_nxt_c == 2'd2) begin
                state <= ST_FULL;
            end else if ((occ_nxt_c == 2'd0) && !bus.readp) begin
                state <= ST_IDLE;
            end else begin
                state <= ST_FILL;
            end
        end
    end
endmodule
